// File: rtl/prio_grant_pkg.sv
// Shared types and constants for the priority grant decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prio_grant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } pg_state_t;

    // Saturation value of the grant counter.
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    // Width of the guard-gap length (GAP_CYC range 0..15).
    localparam int GAP_CW = 4;

endpackage

// File: rtl/prio_hold_counter.sv
// Loadable 8-bit down-counter timing both the grant hold and the guard gap.
// Latency: load/clr/dec take effect at the next clock edge; last is combinational from the count.
// Backpressure: none; the controlling FSM decides when to load or decrement.
//
// Ports: clk, rst (async active-high), load + load_val (highest priority),
//        clr (early clear), dec (decrement, floors at 0), last (count == 1).
module prio_hold_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       clr,
    input  logic       dec,
    output logic       last
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (dec && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign last = (cnt_q == 8'd1);

endmodule

// File: rtl/prio_grant_decoder.sv
// Turns an accepted priority index into a held one-hot grant, then a guard gap.
// Latency: grant rises the cycle after the code handshake; held max(code_hold,1) cycles or until release_i.
// Backpressure: code_ready is low for the whole GRANT+GAP window; upstream holds the code until accepted.
//
// Ports: clk, rst (async active-high); code_valid/code_ready/code_idx/code_hold form the input code
//        channel; release_i ends a grant early; err_clr clears the sticky err_range flag.
//        Outputs grant (one-hot or zero), busy, err_range, grant_count (saturating) are registered.
module prio_grant_decoder
    import prio_grant_pkg::*;
#(
    parameter int N       = 8,
    parameter int IW      = $clog2(N),
    parameter int GAP_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          code_valid,
    output logic          code_ready,
    input  logic [IW-1:0] code_idx,
    input  logic [7:0]    code_hold,
    input  logic          release_i,
    input  logic          err_clr,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic          err_range,
    output logic [15:0]   grant_count
);

    localparam logic [N-1:0]        ONE      = N'(1);
    localparam logic [GAP_CW-1:0]   GAP_LEN  = GAP_CW'(GAP_CYC);
    localparam logic [7:0]          GAP_LOAD = {{(8 - GAP_CW){1'b0}}, GAP_LEN};

    pg_state_t    state_q, state_d;
    logic [N-1:0] grant_d;
    logic         handshake, idx_ok;
    logic         accept, bad_code;
    logic [7:0]   hold_eff;
    logic         cnt_load, cnt_clr, cnt_dec, cnt_last;
    logic [7:0]   cnt_val;

    assign code_ready = (state_q == ST_IDLE);
    assign handshake  = code_valid & code_ready;
    assign idx_ok     = (int'(code_idx) < N);
    // A zero hold would never reach last, so it is treated as a single cycle.
    assign hold_eff   = (code_hold == 8'd0) ? 8'd1 : code_hold;

    prio_hold_counter u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .clr      (cnt_clr),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        accept   = 1'b0;
        bad_code = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = 8'd0;
        cnt_clr  = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (idx_ok) begin
                        accept   = 1'b1;
                        grant_d  = ONE << code_idx;
                        cnt_load = 1'b1;
                        cnt_val  = hold_eff;
                        state_d  = ST_GRANT;
                    end else begin
                        // Out-of-range code is consumed without a grant.
                        bad_code = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                cnt_dec = 1'b1;
                if (cnt_last || release_i) begin
                    grant_d = '0;
                    if (GAP_CYC > 0) begin
                        // Reuse the hold counter as the gap timer.
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                        state_d  = ST_GAP;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            err_range   <= 1'b0;
            grant_count <= 16'd0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            busy    <= (state_d != ST_IDLE);
            // A new range error outranks a simultaneous clear.
            if (bad_code) begin
                err_range <= 1'b1;
            end else if (err_clr) begin
                err_range <= 1'b0;
            end
            if (accept && (grant_count != CNT_SAT)) begin
                grant_count <= grant_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prio_grant_decoder.sv
module tb_prio_grant_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // N=8 instance
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [2:0]  code_idx   = 3'd0;
    logic [7:0]  code_hold  = 8'd0;
    logic        release_i  = 1'b0;
    logic        err_clr    = 1'b0;
    logic [7:0]  grant;
    logic        busy;
    logic        err_range;
    logic [15:0] grant_count;

    // N=6 instance, used for out-of-range codes
    logic        e_valid = 1'b0;
    logic        e_ready;
    logic [2:0]  e_idx   = 3'd0;
    logic        e_clr   = 1'b0;
    logic [5:0]  e_grant;
    logic        e_busy;
    logic        e_err;
    logic [15:0] e_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    prio_grant_decoder #(.N(8), .GAP_CYC(1)) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_ready(code_ready),
        .code_idx(code_idx), .code_hold(code_hold), .release_i(release_i),
        .err_clr(err_clr), .grant(grant), .busy(busy), .err_range(err_range),
        .grant_count(grant_count)
    );

    prio_grant_decoder #(.N(6), .GAP_CYC(1)) dut6 (
        .clk(clk), .rst(rst), .code_valid(e_valid), .code_ready(e_ready),
        .code_idx(e_idx), .code_hold(8'd1), .release_i(1'b0),
        .err_clr(e_clr), .grant(e_grant), .busy(e_busy), .err_range(e_err),
        .grant_count(e_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grants must never be multi-hot, on either instance.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(grant) || !$onehot0(e_grant)) begin
                errors++;
                $display("FAIL onehot: got %0h / %0h expected one-hot or zero", grant, e_grant);
            end
        end
    end

    // Issue one code on the N=8 instance and measure the resulting grant pulse and gap.
    task automatic run_code(input string name, input logic [2:0] idx, input logic [7:0] hold,
                            input int rel_at, input logic [7:0] exp_grant, input int exp_len);
        int len;
        int wait_cyc;
        logic bad_val;
        wait_cyc = 0;
        while (!code_ready && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        if (!code_ready) chk({name, "_ready_timeout"}, 0, 1);
        code_valid = 1'b1;
        code_idx   = idx;
        code_hold  = hold;
        step();
        code_valid = 1'b0;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        chk({name, "_count"}, 32'(grant_count), 32'(exp_cnt));
        chk({name, "_first_grant"}, 32'(grant), 32'(exp_grant));
        len = 0;
        bad_val = 1'b0;
        while (grant != 8'd0 && len < 300) begin
            if (grant !== exp_grant || code_ready !== 1'b0 || busy !== 1'b1) bad_val = 1'b1;
            len++;
            release_i = (len == rel_at);
            step();
            release_i = 1'b0;
        end
        chk({name, "_grant_stable"}, 32'(bad_val), 0);
        chk({name, "_len"}, len, exp_len);
        chk({name, "_gap"}, {30'd0, busy, code_ready}, 32'b10);
        step();
        chk({name, "_idle"}, {30'd0, busy, code_ready}, 32'b01);
    endtask

    typedef struct {
        logic [2:0] idx;
        logic [7:0] hold;
        int         rel_at;
        logic [7:0] exp_grant;
        int         exp_len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3'd3, 8'd4,  0, 8'h08, 4};
        vecs[1] = '{3'd5, 8'd0,  0, 8'h20, 1};
        vecs[2] = '{3'd0, 8'd10, 3, 8'h01, 3};
        vecs[3] = '{3'd7, 8'd1,  0, 8'h80, 1};
        vecs[4] = '{3'd1, 8'd3,  1, 8'h02, 1};
        vecs[5] = '{3'd6, 8'd2,  0, 8'h40, 2};

        // Reset state
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_range), 0);
        chk("rst_count", 32'(grant_count), 0);
        chk("rst_ready", 32'(code_ready), 1);
        step();
        rst = 1'b0;
        step();

        // Release in IDLE is ignored
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        chk("idle_release", {30'd0, busy, code_ready}, 32'b01);

        foreach (vecs[i])
            run_code($sformatf("vec%0d", i), vecs[i].idx, vecs[i].hold, vecs[i].rel_at,
                     vecs[i].exp_grant, vecs[i].exp_len);

        // Out-of-range codes on the N=6 build
        e_valid = 1'b1; e_idx = 3'd7;
        step();
        e_valid = 1'b0;
        chk("oor_err", 32'(e_err), 1);
        chk("oor_grant", 32'(e_grant), 0);
        chk("oor_ready", {30'd0, e_busy, e_ready}, 32'b01);
        chk("oor_count", 32'(e_count), 0);
        step();
        chk("oor_sticky", 32'(e_err), 1);
        e_clr = 1'b1;
        step();
        e_clr = 1'b0;
        chk("oor_clr", 32'(e_err), 0);
        e_valid = 1'b1; e_idx = 3'd6; e_clr = 1'b1;
        step();
        e_valid = 1'b0; e_clr = 1'b0;
        chk("oor_set_wins", 32'(e_err), 1);
        e_valid = 1'b1; e_idx = 3'd5;
        step();
        e_valid = 1'b0;
        chk("n6_grant", 32'(e_grant), 32'h20);
        chk("n6_count", 32'(e_count), 1);

        // Back-to-back codes: second accepted only in first IDLE after the gap
        code_valid = 1'b1; code_idx = 3'd2; code_hold = 8'd2;
        step();
        exp_cnt = exp_cnt + 16'd1;
        code_idx = 3'd4; code_hold = 8'd1;
        chk("b2b_g1", {22'd0, grant, busy, code_ready}, {22'd0, 8'h04, 2'b10});
        step();
        chk("b2b_g2", {22'd0, grant, busy, code_ready}, {22'd0, 8'h04, 2'b10});
        step();
        chk("b2b_gap", {22'd0, grant, busy, code_ready}, {22'd0, 8'h00, 2'b10});
        step();
        chk("b2b_idle", {22'd0, grant, busy, code_ready}, {22'd0, 8'h00, 2'b01});
        step();
        code_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("b2b_second", {22'd0, grant, busy, code_ready}, {22'd0, 8'h10, 2'b10});
        chk("b2b_count", 32'(grant_count), 32'(exp_cnt));
        step();
        step();
        step();

        // Reset in the middle of a long grant
        code_valid = 1'b1; code_idx = 3'd2; code_hold = 8'd20;
        step();
        code_valid = 1'b0;
        repeat (4) step();
        chk("mid_grant", 32'(grant), 32'h04);
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(grant_count), 0);
        chk("arst_ready", 32'(code_ready), 1);
        #2;
        rst = 1'b0;
        exp_cnt = 16'd0;
        step();
        run_code("post_rst", 3'd4, 8'd2, 0, 8'h10, 2);

        // Saturating grant counter
        force dut.grant_count = 16'hFFFE;
        #1;
        release dut.grant_count;
        exp_cnt = 16'hFFFE;
        run_code("sat0", 3'd1, 8'd1, 0, 8'h02, 1);
        run_code("sat1", 3'd2, 8'd1, 0, 8'h04, 1);
        run_code("sat2", 3'd3, 8'd1, 0, 8'h08, 1);
        chk("sat_final", 32'(grant_count), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
